approx_error_monitor: RTL and testbench
=======================================

Name: approx_error_monitor

Overview:
- Sequential checker for approximate-adder netlists produced by the approximation flow (SOP/shared-logic variants).
- Drives an exhaustive input sweep into a combinational approximate circuit and samples its outputs.
- Compares each sample with the exact sum and reports max absolute error, mismatch count and error-threshold (ET) violation.
- Sits in the on-chip/bench validation harness, the reading end of the generated circuit's input/output interface.

Parameters:
- IN_W, 4, total circuit inputs; even; operand width N = IN_W/2.
- OUT_W, 3, circuit output width; must be ≥ N+1.
- ET, 4, error threshold on absolute error (inclusive pass).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a sweep
- stim  out  IN_W  vector driven to circuit inputs; bit i drives in<i>
- approx_out  in  OUT_W  circuit outputs; bit j = out<j>, LSB = out0
- busy  out  1  high during the sweep
- done  out  1  one-cycle pulse when results are final
- max_err  out  OUT_W  maximum |exact − approx| over the sweep
- err_count  out  IN_W+1  number of vectors with nonzero error
- violation  out  1  max_err > ET; valid from done until the next start

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; stim=0; busy=0; done=0; max_err=0; err_count=0; violation=0. Reset mid-sweep aborts the sweep and clears all results.
- Operands: a = stim[N-1:0], b = stim[IN_W-1:N]. exact = a+b, zero-extended to OUT_W (no truncation, because OUT_W ≥ N+1). err = |exact − approx_out|, unsigned, OUT_W bits.
- FSM: IDLE → SWEEP → FIN → IDLE.
- IDLE: start=1 → clear max_err, err_count, violation; stim=0; go to SWEEP.
- SWEEP: busy=1. The circuit is combinational, so approx_out is sampled at the same edge that stim is presented. At each edge:
  - update max_err = max(max_err, err);
  - increment err_count if err≠0;
  - stim++.
- SWEEP exit: on the edge processing stim = 2^IN_W−1, stim wraps to 0 and the state goes to FIN. The sweep is exactly 2^IN_W cycles.
- FIN: done=1 for one cycle; busy=0; violation registered from the final max_err. Next state IDLE.
- Latency: start sampled at edge 0; done high in cycle 2^IN_W+1 (cycle 17 for defaults).
- start while in SWEEP or FIN: ignored. start in the same cycle as rst: rst wins.
- Results hold their values in IDLE until the next accepted start.
- err_count max is 2^IN_W, hence the IN_W+1 width. max_err saturation is not needed, because err ≤ 2^OUT_W−1.
- ET=0: any nonzero error sets violation.

Optional Feature:
- Macro: APPROX_ERR_SUM_EN.
- Defined:
  - extra output sum_err, IN_W+OUT_W bits, accumulating Σerr over the sweep;
  - cleared at reset and at start;
  - valid at done.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package approx_chk_pkg:
  - FSM state enum {IDLE, SWEEP, FIN};
  - localparam helpers for N and the err_count width function;
  - default ET constant.
- One natural sub-module, approx_abs_diff: combinational exact-sum and absolute-difference unit, parameterised by N and OUT_W, instanced once.

Test Plan:
- Approx model constant 3 (out0=1, out1=1, out2=0), defaults → done at cycle 17; max_err=3, err_count=12, violation=0; sum_err=20 with APPROX_ERR_SUM_EN.
- Exact adder model → max_err=0, err_count=0, violation=0, sum_err=0.
- Approx model constant 0 → max_err=6, err_count=15, violation=1; sum_err=48.
- Constant-3 model with ET=0 build → violation=1 with max_err=3. Constant-3 model with ET=3 → violation=0 (boundary inclusive).
- rst asserted at cycle 8 of the sweep → next cycle: busy=0, stim=0, all results 0, no done pulse. A fresh start then completes normally.
- start pulsed at cycles 5 and 17 (FIN) of a running sweep → ignored; single done pulse; results unchanged. start in IDLE afterwards clears results and restarts.

Source files
------------

// File: rtl/approx_chk_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
package approx_chk_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;

  localparam int unsigned DEFAULT_ET = 4;

  function automatic int unsigned op_width(input int unsigned in_w);
    return in_w / 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/approx_abs_diff.sv
// Exact sum of two N-bit operands and its absolute distance from the approximate output.
module approx_abs_diff
  import approx_chk_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned OUT_W = 3
) (
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [OUT_W-1:0] approx,
  output logic [OUT_W-1:0] err
);

  logic [OUT_W-1:0] exact;

  always_comb begin
    exact = OUT_W'(a) + OUT_W'(b);
    err   = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Exhaustive-sweep error monitor for a combinational approximate adder.
// Optional Σerr accumulator/port enabled by defining APPROX_ERR_SUM_EN.
module approx_error_monitor
  import approx_chk_pkg::*;
#(
  parameter int unsigned IN_W = 4,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned ET = DEFAULT_ET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  approx_out,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  max_err,
  output logic [IN_W:0]     err_count,
  output logic              violation
`ifdef APPROX_ERR_SUM_EN
  ,
  output logic [IN_W+OUT_W-1:0] sum_err
`endif
);

  localparam int unsigned N  = op_width(IN_W);
  localparam int unsigned CW = cnt_width(IN_W);
  localparam logic [31:0] ET_W = ET;

  state_t           state, state_next;
  logic [OUT_W-1:0] err;
  logic [OUT_W-1:0] max_next;
  logic             last;

  approx_abs_diff #(.N(N), .OUT_W(OUT_W)) u_diff (
    .a      (stim[N-1:0]),
    .b      (stim[IN_W-1:N]),
    .approx (approx_out),
    .err    (err)
  );

  always_comb begin
    max_next = (err > max_err) ? err : max_err;
    last     = (stim == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (last) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // violation is latched on the final sweep edge so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      stim      <= '0;
      max_err   <= '0;
      err_count <= '0;
      violation <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          stim      <= '0;
          max_err   <= '0;
          err_count <= '0;
          violation <= 1'b0;
        end
        SWEEP: begin
          max_err   <= max_next;
          err_count <= err_count + CW'(err != '0);
          stim      <= stim + IN_W'(1);
          if (last) violation <= ({{(32-OUT_W){1'b0}}, max_next} > ET_W);
        end
        default: ;
      endcase
    end
  end

`ifdef APPROX_ERR_SUM_EN
  always_ff @(posedge clk) begin
    if (rst)                          sum_err <= '0;
    else if (state == IDLE && start)  sum_err <= '0;
    else if (state == SWEEP)          sum_err <= sum_err + (IN_W+OUT_W)'(err);
  end
`endif

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench: three monitors (ET=4, ET=0, ET=3) watch identical circuit models in lockstep.
module tb_approx_error_monitor;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned N     = IN_W / 2;
  localparam int unsigned NV    = 1 << IN_W;

  typedef struct {
    int unsigned mx;
    int unsigned cnt;
    int unsigned sum;
    bit          v4;
    bit          v0;
    bit          v3;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic [IN_W-1:0]  stim, stim_e0, stim_e3;
  logic [OUT_W-1:0] ap, ap_e0, ap_e3;
  logic             busy, busy_e0, busy_e3;
  logic             done, done_e0, done_e3;
  logic [OUT_W-1:0] max_err, max_e0, max_e3;
  logic [IN_W:0]    err_count, cnt_e0, cnt_e3;
  logic             violation, viol_e0, viol_e3;
`ifdef APPROX_ERR_SUM_EN
  logic [IN_W+OUT_W-1:0] sum_err, sum_e0, sum_e3;
`endif

  int unsigned      mode = 0;
  logic [OUT_W-1:0] lut [NV];
  exp_t             exp_q[$];
  exp_t             last_exp;
  int               checks = 0;
  int               failures = 0;
  int unsigned      sweep_idx = 0;

  always #5 clk = ~clk;

  approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .approx_out(ap),
    .busy(busy), .done(done), .max_err(max_err), .err_count(err_count),
    .violation(violation)
`ifdef APPROX_ERR_SUM_EN
    , .sum_err(sum_err)
`endif
  );

  approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(0)) dut_e0 (
    .clk(clk), .rst(rst), .start(start), .stim(stim_e0), .approx_out(ap_e0),
    .busy(busy_e0), .done(done_e0), .max_err(max_e0), .err_count(cnt_e0),
    .violation(viol_e0)
`ifdef APPROX_ERR_SUM_EN
    , .sum_err(sum_e0)
`endif
  );

  approx_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(3)) dut_e3 (
    .clk(clk), .rst(rst), .start(start), .stim(stim_e3), .approx_out(ap_e3),
    .busy(busy_e3), .done(done_e3), .max_err(max_e3), .err_count(cnt_e3),
    .violation(viol_e3)
`ifdef APPROX_ERR_SUM_EN
    , .sum_err(sum_e3)
`endif
  );

  // Circuit under test: 0 = constant 3, 1 = exact adder, 2 = constant 0, other = random table
  function automatic logic [OUT_W-1:0] model(input int unsigned m, input logic [IN_W-1:0] v);
    int unsigned a, b;
    a = int'(v) % (1 << N);
    b = int'(v) / (1 << N);
    case (m)
      0:       return OUT_W'(3);
      1:       return OUT_W'(a + b);
      2:       return '0;
      default: return lut[v];
    endcase
  endfunction

  always_comb ap    = model(mode, stim);
  always_comb ap_e0 = model(mode, stim_e0);
  always_comb ap_e3 = model(mode, stim_e3);

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.mx = 0; e.cnt = 0; e.sum = 0;
    for (int unsigned v = 0; v < NV; v++) begin
      int unsigned ex, apx, d;
      ex  = (v % (1 << N)) + (v / (1 << N));
      apx = int'(model(mode, IN_W'(v)));
      d   = (ex > apx) ? ex - apx : apx - ex;
      if (d > e.mx) e.mx = d;
      if (d != 0) e.cnt++;
      e.sum += d;
    end
    e.v4 = (e.mx > 4);
    e.v0 = (e.mx > 0);
    e.v3 = (e.mx > 3);
    exp_q.push_back(e);
    last_exp = e;
  endtask

  // Monitor: stim walk during busy, scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (busy) begin
      check("stim_seq", int'(stim), sweep_idx);
      sweep_idx++;
    end else begin
      sweep_idx = 0;
    end
    if (done || done_e0 || done_e3) begin
      check("done_lockstep", {29'd0, done, done_e0, done_e3}, 7);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("max_err", int'(max_err), e.mx);
        check("err_count", int'(err_count), e.cnt);
        check("violation_et4", int'(violation), int'(e.v4));
        check("violation_et0", int'(viol_e0), int'(e.v0));
        check("violation_et3", int'(viol_e3), int'(e.v3));
        check("busy_at_done", int'(busy), 0);
`ifdef APPROX_ERR_SUM_EN
        check("sum_err", int'(sum_err), e.sum);
`endif
      end
    end
  end

  task automatic check_results_hold(input string tag);
    check({tag, "_max_err"}, int'(max_err), last_exp.mx);
    check({tag, "_err_count"}, int'(err_count), last_exp.cnt);
    check({tag, "_violation"}, int'(violation), int'(last_exp.v4));
    check({tag, "_busy"}, int'(busy), 0);
`ifdef APPROX_ERR_SUM_EN
    check({tag, "_sum_err"}, int'(sum_err), last_exp.sum);
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_stim"}, int'(stim), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_max_err"}, int'(max_err), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_violation"}, int'(violation), 0);
`ifdef APPROX_ERR_SUM_EN
    check({tag, "_sum_err"}, int'(sum_err), 0);
`endif
  endtask

  // Start a sweep and wait for done; optionally pulse start at cycle 5 and in the FIN cycle
  task automatic do_sweep(input int unsigned m, input bit poke_start);
    int unsigned n;
    bit got;
    mode = m;
    if (m >= 3)
      for (int unsigned i = 0; i < NV; i++) lut[i] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
    @(negedge clk);
    push_expected();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk);
      n++;
      #1;
      start = (poke_start && n == 4);
      if (done) got = 1'b1;
    end
    check("done_latency", n, NV);
    if (poke_start && got) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 check_results_hold("after_ignored_start");
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    for (int unsigned i = 0; i < NV; i++) lut[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    do_sweep(0, 1'b0);
    do_sweep(1, 1'b0);
    do_sweep(2, 1'b0);
    repeat (4) @(posedge clk);
    #1 check_results_hold("idle_hold");
    for (int k = 0; k < 4; k++) do_sweep(3, 1'b0);

    // Reset during cycle 8 of a sweep
    mode = 0;
    @(negedge clk);
    push_expected();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    exp_q.delete();
    check_cleared("mid_sweep_reset");
    repeat (24) @(posedge clk);
    #1 check_cleared("post_reset_idle");

    do_sweep(0, 1'b0);
    do_sweep(2, 1'b1);
    do_sweep(0, 1'b0);
    do_sweep(3, 1'b0);

    repeat (5) @(posedge clk);
    check("pending_done", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
